// File: rtl/reaction_game_ctrl_if.sv
// Interface between the reaction-game controller and the seven-segment display side.
// master : controller (consumes button pulses, drives display number/select/mode and lamps)
// slave  : button/display side (drives button pulses, observes controller outputs)
//   btn_start / btn_react / btn_mode : single-cycle debounced button pulses
//   number  : result in ms to display      select : 0 mode name, 1 number
//   mode    : 0 easy, 1 regular, 2 hard    led    : GO lamp
//   fault   : false start flag             timeout: window expired flag
interface reaction_game_ctrl_if;
  logic        btn_start;
  logic        btn_react;
  logic        btn_mode;
  logic [13:0] number;
  logic        select;
  logic [1:0]  mode;
  logic        led;
  logic        fault;
  logic        timeout;

  modport master (
    input  btn_start, btn_react, btn_mode,
    output number, select, mode, led, fault, timeout
  );

  modport slave (
    output btn_start, btn_react, btn_mode,
    input  number, select, mode, led, fault, timeout
  );
endinterface

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game controller feeding a 4-digit seven-segment display driver.
// Sequences one trial: mode select, random hold-off, GO lamp, millisecond count, result.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : reaction_game_ctrl_if.master (buttons in; number/select/mode/led/fault/timeout out)
module reaction_game_ctrl #(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned SPAN_BITS    = 11,
  parameter int unsigned LIMIT_EASY   = 2000,
  parameter int unsigned LIMIT_REG    = 1000,
  parameter int unsigned LIMIT_HARD   = 500
) (
  input  logic                        clk,
  input  logic                        rst_n,
  reaction_game_ctrl_if.master        bus
);

  localparam int unsigned PscW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StGo,
    StFault,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [PscW-1:0] psc_q, psc_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [11:0]     delay_q, delay_d;
  logic [13:0]     count_q, count_d;
  logic [13:0]     number_q, number_d;
  logic            select_q, select_d;
  logic [1:0]      mode_q, mode_d;
  logic            led_q, led_d;
  logic            fault_q, fault_d;
  logic            timeout_q, timeout_d;

  logic            tick;
  logic            lfsr_fb;
  logic [13:0]     limit;
  logic [13:0]     count_inc;

  assign tick      = (psc_q == PscW'(TICK_DIV - 1));
  assign count_inc = count_q + 14'd1;

  // Fibonacci LFSR, taps 16,14,13,11 (shift-right form); a non-zero seed never reaches zero.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign lfsr_d  = {lfsr_fb, lfsr_q[15:1]};

  always_comb begin
    limit = 14'(LIMIT_EASY);
    unique case (mode_q)
      2'd1:    limit = 14'(LIMIT_REG);
      2'd2:    limit = 14'(LIMIT_HARD);
      default: limit = 14'(LIMIT_EASY);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    psc_d     = tick ? '0 : psc_q + 1'b1;
    delay_d   = delay_q;
    count_d   = count_q;
    number_d  = number_q;
    select_d  = select_q;
    mode_d    = mode_q;
    led_d     = led_q;
    fault_d   = fault_q;
    timeout_d = timeout_q;

    unique case (state_q)
      StIdle: begin
        select_d = 1'b0;
        led_d    = 1'b0;
        // btn_react has no meaning here, so start outranks mode.
        if (bus.btn_start) begin
          delay_d   = 12'(MIN_DELAY_MS) + 12'(lfsr_q[SPAN_BITS-1:0]);
          fault_d   = 1'b0;
          timeout_d = 1'b0;
          number_d  = '0;
          psc_d     = '0;
          state_d   = StWait;
        end else if (bus.btn_mode) begin
          mode_d = (mode_q == 2'd2) ? 2'd0 : mode_q + 2'd1;
        end
      end

      StWait: begin
        if (bus.btn_react) begin
          number_d = '0;
          fault_d  = 1'b1;
          select_d = 1'b1;
          led_d    = 1'b0;
          state_d  = StFault;
        end else if (tick) begin
          // Test for <= 1 so a zero-length hold-off cannot wrap the counter.
          if (delay_q <= 12'd1) begin
            delay_d = '0;
            count_d = '0;
            psc_d   = '0;
            led_d   = 1'b1;
            state_d = StGo;
          end else begin
            delay_d = delay_q - 12'd1;
          end
        end
      end

      StGo: begin
        led_d = 1'b1;
        if (bus.btn_react) begin
          // Completed ms only; a tick landing on this cycle is not counted.
          number_d = count_q;
          led_d    = 1'b0;
          select_d = 1'b1;
          state_d  = StDone;
        end else if (tick) begin
          if (count_inc == limit) begin
            number_d  = limit;
            timeout_d = 1'b1;
            led_d     = 1'b0;
            select_d  = 1'b1;
            state_d   = StDone;
          end else begin
            count_d = count_inc;
          end
        end
      end

      StFault, StDone: begin
        if (bus.btn_start) begin
          select_d = 1'b0;
          state_d  = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      psc_q     <= '0;
      lfsr_q    <= 16'hACE1;
      delay_q   <= '0;
      count_q   <= '0;
      number_q  <= '0;
      select_q  <= 1'b0;
      mode_q    <= 2'd0;
      led_q     <= 1'b0;
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      psc_q     <= psc_d;
      lfsr_q    <= lfsr_d;
      delay_q   <= delay_d;
      count_q   <= count_d;
      number_q  <= number_d;
      select_q  <= select_d;
      mode_q    <= mode_d;
      led_q     <= led_d;
      fault_q   <= fault_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.number  = number_q;
  assign bus.select  = select_q;
  assign bus.mode    = mode_q;
  assign bus.led     = led_q;
  assign bus.fault   = fault_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Self-checking bench for reaction_game_ctrl with small timing parameters.
module tb_reaction_game_ctrl;

  localparam int TD   = 4;
  localparam int MIN  = 2;
  localparam int SPAN = 2;
  localparam int LE   = 12;
  localparam int LR   = 8;
  localparam int LH   = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reaction_game_ctrl_if game_if ();

  reaction_game_ctrl #(
    .TICK_DIV    (TD),
    .MIN_DELAY_MS(MIN),
    .SPAN_BITS   (SPAN),
    .LIMIT_EASY  (LE),
    .LIMIT_REG   (LR),
    .LIMIT_HARD  (LH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (game_if)
  );

  int total = 0;
  int bad   = 0;

  // Reference LFSR: same polynomial, stepped once per clock while out of reset.
  logic [15:0] m_lfsr;
  int          m_mode;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic [15:0] b;
    b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'h0001;
    return (l >> 1) | (b << 15);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic int limit_of(input int md);
    return (md == 1) ? LR : (md == 2) ? LH : LE;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press_mode();
    game_if.btn_mode = 1'b1;
    @(negedge clk);
    game_if.btn_mode = 1'b0;
    m_mode = (m_mode + 1) % 3;
    check("mode_step", game_if.mode, m_mode);
    check("mode_select", game_if.select, 0);
  endtask

  task automatic pulse_start();
    game_if.btn_start = 1'b1;
    @(negedge clk);
    game_if.btn_start = 1'b0;
  endtask

  // Returns hold-off in ms for a start issued at the current negedge.
  function automatic int hold_ms();
    return MIN + int'(m_lfsr[SPAN-1:0]);
  endfunction

  // After the start edge: count edges until led rises (bounded).
  task automatic wait_go(input int d);
    int k;
    k = 0;
    check("wait_led_low", game_if.led, 0);
    while (game_if.led !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("go_latency", k, TD * d);
  endtask

  // React pulse sampled on the n-th edge counted from the GO (or WAIT) entry edge.
  task automatic react_after(input int n, input logic with_start);
    repeat (n - 1) @(negedge clk);
    game_if.btn_react = 1'b1;
    game_if.btn_start = with_start;
    @(negedge clk);
    game_if.btn_react = 1'b0;
    game_if.btn_start = 1'b0;
  endtask

  task automatic expect_result(input int n);
    int lim, num, to;
    lim = limit_of(m_mode);
    if (n <= TD * lim) begin
      num = (n - 1) / TD;
      to  = 0;
    end else begin
      num = lim;
      to  = 1;
    end
    check("res_number", game_if.number, num);
    check("res_timeout", game_if.timeout, to);
    check("res_fault", game_if.fault, 0);
    check("res_select", game_if.select, 1);
    check("res_led", game_if.led, 0);
  endtask

  task automatic expect_fault();
    check("flt_number", game_if.number, 0);
    check("flt_fault", game_if.fault, 1);
    check("flt_select", game_if.select, 1);
    check("flt_led", game_if.led, 0);
  endtask

  initial begin
    int d, n, j, hi, k, presses;
    logic [13:0] held;

    game_if.btn_start = 1'b0;
    game_if.btn_react = 1'b0;
    game_if.btn_mode  = 1'b0;
    m_mode = 0;
    rst_n  = 1'b0;
    #12;
    check("rst_number", game_if.number, 0);
    check("rst_select", game_if.select, 0);
    check("rst_mode", game_if.mode, 0);
    check("rst_led", game_if.led, 0);
    check("rst_fault", game_if.fault, 0);
    check("rst_timeout", game_if.timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode cycling 0->1->2->0.
    repeat (3) press_mode();

    // Normal trial, react after 3 completed ticks.
    d = hold_ms();
    pulse_start();
    wait_go(d);
    react_after(13, 1'b0);
    expect_result(13);
    held = game_if.number;
    press_mode_ignored: begin
      game_if.btn_mode = 1'b1;
      @(negedge clk);
      game_if.btn_mode = 1'b0;
      check("done_mode_ignored", game_if.mode, m_mode);
    end
    pulse_start();
    check("back_idle_select", game_if.select, 0);
    check("back_idle_number", game_if.number, held);

    // False start: led must never rise.
    pulse_start();
    react_after(2, 1'b0);
    expect_fault();
    hi = 0;
    for (int c = 0; c < 6 * TD; c++) begin
      @(negedge clk);
      if (game_if.led === 1'b1) hi++;
    end
    check("flt_led_never", hi, 0);
    pulse_start();
    check("flt_idle_select", game_if.select, 0);
    check("flt_flag_kept", game_if.fault, 1);

    // Hard mode timeout, then react exactly on the limit tick.
    press_mode();
    press_mode();
    d = hold_ms();
    pulse_start();
    wait_go(d);
    check("start_cleared_fault", game_if.fault, 0);
    k = 0;
    while (game_if.select !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", k, TD * LH);
    expect_result(TD * LH + 1);
    pulse_start();
    d = hold_ms();
    pulse_start();
    wait_go(d);
    react_after(TD * LH, 1'b0);
    expect_result(TD * LH);
    pulse_start();

    // start + mode together in IDLE: start wins, mode unchanged.
    d = hold_ms();
    game_if.btn_mode = 1'b1;
    pulse_start();
    game_if.btn_mode = 1'b0;
    check("start_mode_same", game_if.mode, m_mode);
    wait_go(d);
    // start + react together in GO: react wins.
    react_after(9, 1'b1);
    expect_result(9);
    pulse_start();

    // Randomized trials.
    for (int t = 0; t < 10; t++) begin
      presses = $urandom_range(2, 0);
      repeat (presses) press_mode();
      d = hold_ms();
      pulse_start();
      if ($urandom_range(3, 0) == 0) begin
        j = $urandom_range(TD * d, 1);
        react_after(j, 1'b0);
        expect_fault();
      end else begin
        wait_go(d);
        n = $urandom_range(TD * limit_of(m_mode) + 6, 1);
        react_after(n, 1'b0);
        expect_result(n);
      end
      pulse_start();
      check("rnd_idle_select", game_if.select, 0);
    end

    // Asynchronous reset while in GO.
    if (m_mode == 0) press_mode();
    d = hold_ms();
    pulse_start();
    wait_go(d);
    repeat (3) @(negedge clk);
    check("pre_rst_led", game_if.led, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_led", game_if.led, 0);
    check("arst_select", game_if.select, 0);
    check("arst_number", game_if.number, 0);
    check("arst_mode", game_if.mode, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_mode = 0;
    // Model LFSR restarts at ACE1, so the next hold-off proves the DUT seed reloaded.
    d = hold_ms();
    pulse_start();
    wait_go(d);
    react_after(5, 1'b0);
    expect_result(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
